// File: rtl/multi_data_sync.sv
// -----------------------------------------------------------------------------
// multi_data_sync
//
// Destination-domain synchroniser for NUM_CH independent quasi-static buses.
// Each channel runs its asynchronous qualifier (bus_enable[c]) through a
// NUM_STAGES-deep flop chain. It then detects an event on the chain output and
// samples the source bus into a held output register.
//
// Parameters:
//   NUM_STAGES : synchroniser depth per channel (2..4)
//   BUS_WIDTH  : data width per channel
//   NUM_CH     : number of channels (1..8)
//   EDGE_MODE  : 0 = rising edge of synchronised enable, 1 = any transition
//
// Ports:
//   CLK          destination clock
//   RST          synchronous reset, active-low
//   unsync_bus   source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable   asynchronous per-channel qualifier
//   sync_ready   consumer accepts the held word of channel c
//   overrun_clr  clears the sticky overrun flag of channel c
//   sync_bus     captured data, same packing as unsync_bus
//   enable_pulse one-cycle strobe per capture
//   sync_valid   channel c holds an unconsumed word
//   overrun      sticky: a capture overwrote an unconsumed word
//
// Handshake (per channel): sync_valid rises on a capture and stays high until
// an edge where sync_ready is high and no new capture happens. sync_ready has
// no effect while sync_valid is low. A capture on the same edge as sync_ready
// replaces the word and keeps sync_valid high. The old word counts as consumed,
// so overrun is not set in that case. sync_bus never changes on consumption.
// -----------------------------------------------------------------------------
module multi_data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 2,
    parameter int EDGE_MODE  = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH-1:0]           sync_ready,
    input  logic [NUM_CH-1:0]           overrun_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           sync_valid,
    output logic [NUM_CH-1:0]           overrun
);

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [NUM_STAGES-1:0] sync_chain;   // [0] is the metastability-exposed flop
            logic                  hist;         // chain output delayed by one edge
            logic                  evt;
            logic [BUS_WIDTH-1:0]  data_q;
            logic                  pulse_q;
            logic                  valid_q;
            logic                  ovr_q;
            logic                  ovr_set;

            if (EDGE_MODE == 1) begin : g_toggle
                assign evt = sync_chain[NUM_STAGES-1] ^ hist;
            end else begin : g_rise
                assign evt = sync_chain[NUM_STAGES-1] & ~hist;
            end

            // Overwriting a held word counts as an overrun only when the consumer
            // is not taking that word on the same edge.
            assign ovr_set = evt & valid_q & ~sync_ready[c];

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    sync_chain <= '0;
                    hist       <= 1'b0;
                end else begin
                    sync_chain <= {sync_chain[NUM_STAGES-2:0], bus_enable[c]};
                    hist       <= sync_chain[NUM_STAGES-1];
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    data_q  <= '0;
                    pulse_q <= 1'b0;
                    valid_q <= 1'b0;
                    ovr_q   <= 1'b0;
                end else begin
                    pulse_q <= evt;
                    if (evt) begin
                        data_q <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    end
                    if (evt) begin
                        valid_q <= 1'b1;
                    end else if (sync_ready[c]) begin
                        valid_q <= 1'b0;
                    end
                    // A new overrun wins over a clear on the same edge.
                    if (ovr_set) begin
                        ovr_q <= 1'b1;
                    end else if (overrun_clr[c]) begin
                        ovr_q <= 1'b0;
                    end
                end
            end

            assign sync_bus[c*BUS_WIDTH +: BUS_WIDTH] = data_q;
            assign enable_pulse[c]                    = pulse_q;
            assign sync_valid[c]                      = valid_q;
            assign overrun[c]                         = ovr_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_data_sync.sv
// -----------------------------------------------------------------------------
// tb_multi_data_sync
//
// Two instances share the stimulus:
//   inst 0 : NUM_STAGES=2, EDGE_MODE=0 (rising edge)
//   inst 1 : NUM_STAGES=3, EDGE_MODE=1 (toggle)
// The reference model records every sampled enable level per edge, together
// with the last reset edge. It derives each capture from the rule
// "the level sampled NUM_STAGES edges ago against the one before it".
// -----------------------------------------------------------------------------
module tb_multi_data_sync;

    localparam int NCH  = 2;
    localparam int W    = 8;
    localparam int NI   = 2;
    localparam int HMAX = 4096;

    logic              clk;
    logic              rst_n;
    logic [NCH*W-1:0]  ubus;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    rdy;
    logic [NCH-1:0]    oclr;

    logic [NCH*W-1:0]  o_bus   [NI];
    logic [NCH-1:0]    o_pulse [NI];
    logic [NCH-1:0]    o_valid [NI];
    logic [NCH-1:0]    o_ovr   [NI];

    int checks   = 0;
    int failures = 0;

    multi_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(W), .NUM_CH(NCH), .EDGE_MODE(0)) dut0 (
        .CLK(clk), .RST(rst_n), .unsync_bus(ubus), .bus_enable(en),
        .sync_ready(rdy), .overrun_clr(oclr),
        .sync_bus(o_bus[0]), .enable_pulse(o_pulse[0]),
        .sync_valid(o_valid[0]), .overrun(o_ovr[0])
    );

    multi_data_sync #(.NUM_STAGES(3), .BUS_WIDTH(W), .NUM_CH(NCH), .EDGE_MODE(1)) dut1 (
        .CLK(clk), .RST(rst_n), .unsync_bus(ubus), .bus_enable(en),
        .sync_ready(rdy), .overrun_clr(oclr),
        .sync_bus(o_bus[1]), .enable_pulse(o_pulse[1]),
        .sync_valid(o_valid[1]), .overrun(o_ovr[1])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int  cyc      = 0;           // index of the most recent rising edge
    int  last_rst = -1;          // most recent edge with reset asserted
    bit  en_hist [NCH][HMAX];
    logic [W-1:0] m_bus   [NI][NCH];
    bit           m_valid [NI][NCH];
    bit           m_ovr   [NI][NCH];
    logic [39:0]  exp_q   [NI*NCH][$];   // {capture edge, data}

    function automatic int ns_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int mode_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Level seen at the end of the chain from sampling edge k; a reset at or
    // after k wipes that sample.
    function automatic bit seen_lvl(input int c, input int k);
        if (k < 0 || k <= last_rst) return 1'b0;
        return en_hist[c][k];
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < NCH; c++) en_hist[c][cyc % HMAX] = en[c];
        if (!rst_n) begin
            last_rst = cyc;
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    m_bus[i][c]   = '0;
                    m_valid[i][c] = 1'b0;
                    m_ovr[i][c]   = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    bit cur, prv, evt;
                    cur = seen_lvl(c, cyc - ns_of(i));
                    prv = seen_lvl(c, cyc - ns_of(i) - 1);
                    evt = (mode_of(i) == 1) ? (cur ^ prv) : (cur & ~prv);
                    if (evt && m_valid[i][c] && !rdy[c]) m_ovr[i][c] = 1'b1;
                    else if (oclr[c])                    m_ovr[i][c] = 1'b0;
                    if (evt) begin
                        m_bus[i][c]   = ubus[c*W +: W];
                        m_valid[i][c] = 1'b1;
                        exp_q[i*NCH+c].push_back({32'(cyc), ubus[c*W +: W]});
                    end else if (rdy[c]) begin
                        m_valid[i][c] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int pulse_cnt  [NI][NCH];
    int last_pulse [NI][NCH];

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    int q;
                    logic [39:0] e;
                    q = i*NCH + c;
                    if (o_pulse[i][c] === 1'b1) begin
                        pulse_cnt[i][c]++;
                        last_pulse[i][c] = cyc;
                        if (exp_q[q].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL pulse_unexpected inst=%0d ch=%0d actual=pulse@%0d required=none", i, c, cyc);
                        end else begin
                            e = exp_q[q].pop_front();
                            chk($sformatf("pulse_cycle i%0d c%0d", i, c), 32'(cyc), e[39:8]);
                            chk($sformatf("pulse_data i%0d c%0d", i, c), 32'(o_bus[i][c*W +: W]), 32'(e[7:0]));
                        end
                    end else if (exp_q[q].size() > 0) begin
                        e = exp_q[q].pop_front();
                        chk($sformatf("pulse_missing i%0d c%0d", i, c), 32'(o_pulse[i][c]), 32'd1);
                    end
                    chk($sformatf("bus i%0d c%0d @%0d", i, c, cyc), 32'(o_bus[i][c*W +: W]), 32'(m_bus[i][c]));
                    chk($sformatf("valid i%0d c%0d @%0d", i, c, cyc), 32'(o_valid[i][c]), 32'(m_valid[i][c]));
                    chk($sformatf("overrun i%0d c%0d @%0d", i, c, cyc), 32'(o_ovr[i][c]), 32'(m_ovr[i][c]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int c, input logic [W-1:0] d);
        ubus[c*W +: W] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e1, e2, r, pc0, pc1;
        rst_n = 1'b0;
        ubus  = '0;
        en    = '0;
        rdy   = '0;
        oclr  = '0;
        tick(3);
        for (int i = 0; i < NI; i++) begin
            chk("reset_bus", 32'(o_bus[i]), 32'd0);
            chk("reset_pulse", 32'(o_pulse[i]), 32'd0);
            chk("reset_valid", 32'(o_valid[i]), 32'd0);
            chk("reset_ovr", 32'(o_ovr[i]), 32'd0);
        end
        rst_n = 1'b1;
        tick(3);

        // 1: single rising edge, held high
        set_data(0, 8'hA5);
        en[0] = 1'b1;
        e1  = cyc + 1;
        pc0 = pulse_cnt[0][0];
        tick(6);
        chk("t1_pulse_count", 32'(pulse_cnt[0][0] - pc0), 32'd1);
        chk("t1_pulse_edge", 32'(last_pulse[0][0]), 32'(e1 + 2));
        chk("t1_bus", 32'(o_bus[0][7:0]), 32'hA5);
        chk("t1_valid", 32'(o_valid[0][0]), 32'd1);
        chk("t1_ch1_valid", 32'(o_valid[0][1]), 32'd0);
        chk("t1_ch1_bus", 32'(o_bus[0][15:8]), 32'd0);

        // 2: handshake on ch1
        set_data(1, 8'h3C);
        en[1] = 1'b1;
        tick(4);
        rdy[1] = 1'b1;
        tick(1);
        rdy[1] = 1'b0;
        chk("t2_valid", 32'(o_valid[0][1]), 32'd0);
        chk("t2_bus", 32'(o_bus[0][15:8]), 32'h3C);
        chk("t2_ovr", 32'(o_ovr[0][1]), 32'd0);

        // 3: overrun on ch0 (consume the 0xA5 first)
        rdy[0] = 1'b1;
        tick(1);
        rdy[0] = 1'b0;
        en[0] = 1'b0;
        tick(3);
        set_data(0, 8'h11);
        en[0] = 1'b1;
        tick(4);
        en[0] = 1'b0;
        tick(3);
        set_data(0, 8'h22);
        en[0] = 1'b1;
        tick(4);
        chk("t3_bus", 32'(o_bus[0][7:0]), 32'h22);
        chk("t3_valid", 32'(o_valid[0][0]), 32'd1);
        chk("t3_ovr", 32'(o_ovr[0][0]), 32'd1);
        oclr[0] = 1'b1;
        tick(1);
        oclr[0] = 1'b0;
        chk("t3_ovr_clr", 32'(o_ovr[0][0]), 32'd0);

        // 4: capture coincides with ready on a pending word
        en[1] = 1'b0;
        tick(3);
        set_data(1, 8'h44);
        en[1] = 1'b1;
        tick(4);
        en[1] = 1'b0;
        tick(3);
        set_data(1, 8'h55);
        en[1] = 1'b1;
        tick(2);
        rdy[1] = 1'b1;
        tick(1);
        rdy[1] = 1'b0;
        chk("t4_valid", 32'(o_valid[0][1]), 32'd1);
        chk("t4_bus", 32'(o_bus[0][15:8]), 32'h55);
        chk("t4_ovr", 32'(o_ovr[0][1]), 32'd0);
        tick(6);

        // 5: toggle protocol on inst 1
        set_data(0, 8'h01);
        en[0] = ~en[0];
        e1  = cyc + 1;
        pc1 = pulse_cnt[1][0];
        tick(4);
        set_data(0, 8'h02);
        en[0] = ~en[0];
        e2 = cyc + 1;
        tick(6);
        chk("t5_pulse_count", 32'(pulse_cnt[1][0] - pc1), 32'd2);
        chk("t5_pulse_edge", 32'(last_pulse[1][0]), 32'(e2 + 3));
        chk("t5_bus", 32'(o_bus[1][7:0]), 32'h02);
        chk("t5_first_toggle_edge", 32'(e2 - e1), 32'd4);

        // 6: reset while an event is in flight
        en[0] = 1'b0;
        tick(6);
        en[0] = 1'b1;
        tick(1);
        rst_n = 1'b0;
        pc0 = pulse_cnt[0][0];
        pc1 = pulse_cnt[1][0];
        tick(1);
        for (int i = 0; i < NI; i++) begin
            chk("t6_rst_bus", 32'(o_bus[i]), 32'd0);
            chk("t6_rst_pulse", 32'(o_pulse[i]), 32'd0);
            chk("t6_rst_valid", 32'(o_valid[i]), 32'd0);
            chk("t6_rst_ovr", 32'(o_ovr[i]), 32'd0);
        end
        tick(1);
        rst_n = 1'b1;
        r = cyc + 1;
        tick(6);
        chk("t6_pulse_count0", 32'(pulse_cnt[0][0] - pc0), 32'd1);
        chk("t6_pulse_edge0", 32'(last_pulse[0][0]), 32'(r + 2));
        chk("t6_pulse_count1", 32'(pulse_cnt[1][0] - pc1), 32'd1);
        chk("t6_pulse_edge1", 32'(last_pulse[1][0]), 32'(r + 3));

        // random phase
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 1) == 0) set_data(c, W'($urandom));
                rdy[c]  = ($urandom_range(0, 2) == 0);
                oclr[c] = ($urandom_range(0, 7) == 0);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        rdy   = '0;
        oclr  = '0;
        tick(10);
        for (int q = 0; q < NI*NCH; q++) begin
            chk($sformatf("exp_q_drained q%0d", q), 32'(exp_q[q].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_data_sync.md
Name: multi_data_sync

Overview:
Multi-channel, parametrised successor to the single-channel bus synchroniser. It lives in the destination clock domain. Each channel passes a qualifier (bus_enable) through an NUM_STAGES-deep flop chain, detects the qualifier event, and then samples the quasi-static source bus into a destination register. New versus the previous generation: NUM_CH independent channels, a selectable event mode (level-rising or toggle), a per-channel valid/ready hold handshake toward the consumer, and sticky overrun detection.

Parameters:
NUM_STAGES, 2, synchroniser depth per channel; legal range 2..4.
BUS_WIDTH, 8, data width per channel.
NUM_CH, 2, number of independent channels; legal range 1..8.
EDGE_MODE, 0, event type. 0 = rising edge of the synchronised enable. 1 = any transition (toggle protocol).

Ports:
CLK  input  1  destination-domain clock.
RST  input  1  synchronous reset, active-low.
unsync_bus  input  NUM_CH*BUS_WIDTH  source data; channel c occupies [c*BUS_WIDTH +: BUS_WIDTH]; held stable by the source around each event.
bus_enable  input  NUM_CH  asynchronous per-channel qualifier, one bit per channel.
sync_ready  input  NUM_CH  consumer accepts the held word of channel c.
overrun_clr  input  NUM_CH  clears the sticky overrun flag of channel c.
sync_bus  output  NUM_CH*BUS_WIDTH  captured data, registered, same packing as unsync_bus.
enable_pulse  output  NUM_CH  one-cycle registered strobe per capture.
sync_valid  output  NUM_CH  channel c holds an unconsumed word.
overrun  output  NUM_CH  sticky flag: a capture overwrote an unconsumed word.

Behaviour:
- Reset:
  - Synchronous only: all state is cleared on the CLK edge where RST=0. This covers the sync chains, the edge-history flop, sync_bus, enable_pulse, sync_valid and overrun.
  - All outputs read 0 on the first edge with RST=0.
  - Reset mid-operation discards any event still in flight and any held word.
- Channels are fully independent; no shared state and no arbitration between channels.
- Sync chain per channel:
  - s[0] <= bus_enable[c]; s[i] <= s[i-1]; plus history flop p <= s[NUM_STAGES-1].
- Event detect (combinational):
  - EDGE_MODE=0: evt = s[NUM_STAGES-1] & ~p.
  - EDGE_MODE=1: evt = s[NUM_STAGES-1] ^ p.
- Capture, on the edge where evt=1:
  - sync_bus[c] <= unsync_bus[c].
  - enable_pulse[c] <= 1.
  - sync_valid[c] <= 1.
  - On every other edge, enable_pulse[c] <= 0 and sync_bus[c] holds.
- Latency:
  - Count from the first edge that samples a new bus_enable level (edge E).
  - enable_pulse, sync_bus and sync_valid update on edge E+NUM_STAGES.
  - With NUM_STAGES=2, enable_pulse is high in the cycle after the 3rd sampling edge.
- enable_pulse:
  - Exactly one cycle wide per event, regardless of how long bus_enable stays high.
  - EDGE_MODE=0: no event on a falling edge.
- Consumer handshake:
  - If sync_valid[c]=1 and sync_ready[c]=1 with no capture on that edge, sync_valid[c] <= 0. sync_bus keeps its value.
  - sync_ready while sync_valid=0 has no effect.
- Simultaneous capture and ready:
  - The capture wins: sync_valid stays 1 and the data is replaced.
  - No overrun, because the old word is consumed in the same cycle.
- Overrun:
  - A capture while sync_valid[c]=1 and sync_ready[c]=0 overwrites the data (newest wins) and sets overrun[c].
  - overrun[c] stays set until an edge with overrun_clr[c]=1.
  - If a clear and a new overrun occur on the same edge, set wins.
- Reset-release corner (EDGE_MODE=1): if bus_enable is held high through reset, it produces one event NUM_STAGES edges after release. That event is legal and documented.
- Events spaced closer than 2 destination cycles at the chain output:
  - In EDGE_MODE=1, every transition produces its own pulse.
  - In EDGE_MODE=0, a high pulse shorter than one destination cycle may be lost. Sources must hold the enable high for at least 2 destination cycles.

Test Plan:
1. NUM_STAGES=2, EDGE_MODE=0. Ch0: unsync_bus=0xA5, bus_enable 0->1, held high for 6 cycles. Required: exactly one enable_pulse, on sampling edge +2. sync_bus ch0=0xA5; sync_valid=1; ch1 outputs unchanged.
2. Handshake, ch1. Capture 0x3C, then sync_ready=1 for one cycle. Required: sync_valid drops on that edge; sync_bus stays 0x3C; overrun=0.
3. Overrun. Ch0 captures 0x11 (no ready), then 0x22. Required: sync_bus=0x22, sync_valid=1, overrun=1. Pulse overrun_clr: overrun=0 on the next edge.
4. Simultaneous. The capture edge of 0x55 coincides with sync_ready=1 on a pending 0x44. Required: sync_valid stays 1, sync_bus=0x55, overrun stays 0.
5. EDGE_MODE=1, NUM_STAGES=3. Toggle bus_enable 0->1->0 with 4 cycles between toggles, data 0x01 then 0x02. Required: two pulses, each 3 edges after its toggle is sampled; sync_bus ends at 0x02.
6. Reset mid-flight. Assert RST=0 one cycle after the enable rises. Required: no pulse; all outputs 0 on that edge. With enable held high after release, EDGE_MODE=0 captures once, NUM_STAGES edges after release.
